// File: rtl/camera_patrol_ctrl.sv
// Security-camera patrol sequencer: sweeps camX between playfield limits,
// dwells at each edge and freezes into an alert hold when the player is seen.
module camera_patrol_ctrl #(
  parameter int unsigned CAM_X_MIN    = 10,
  parameter int unsigned CAM_X_MAX    = 639,
  parameter int unsigned CAM_X_START  = 40,
  parameter int unsigned DWELL_FRAMES = 60,
  parameter int unsigned ALERT_FRAMES = 120,
  parameter int unsigned VIEW_RANGE   = 80
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [3:0] cam_step,
  input  logic [9:0] camS,
  input  logic [9:0] playerX,
  input  logic       player_valid,
  output logic [9:0] camX,
  output logic [1:0] direction_cam,
  output logic       alert
);

  typedef enum logic [1:0] {
    ST_SWEEP_L = 2'b00,
    ST_SWEEP_R = 2'b01,
    ST_DWELL   = 2'b10,
    ST_ALERT   = 2'b11
  } state_t;

  localparam logic [11:0] MIN12     = 12'(CAM_X_MIN);
  localparam logic [11:0] MAX12     = 12'(CAM_X_MAX);
  localparam logic [11:0] VR12      = 12'(VIEW_RANGE);
  localparam logic [9:0]  START10   = 10'(CAM_X_START);
  localparam logic [7:0]  DWELL_CNT = 8'(DWELL_FRAMES - 1);
  localparam logic [7:0]  ALERT_CNT = 8'(ALERT_FRAMES - 1);

  // Saturate a widened position back into the 10-bit pixel range.
  function automatic logic [9:0] sat10(input logic [11:0] v);
    if (v > 12'd1023) begin
      sat10 = 10'd1023;
    end else begin
      sat10 = v[9:0];
    end
  endfunction

  state_t      r_state;
  logic [9:0]  r_camx;
  logic [7:0]  r_cnt;
  logic        r_resume_right;
  logic        r_alert;

  state_t      w_state_nxt;
  logic [9:0]  w_camx_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_resume_nxt;
  logic        w_alert_nxt;

  logic [3:0]  w_step;
  logic [11:0] w_x12;
  logic [11:0] w_s12;
  logic [11:0] w_st12;
  logic [11:0] w_p12;
  logic [11:0] w_lo_bound;
  logic        w_sight_l;
  logic        w_sight_r;
  logic        w_edge_l;
  logic        w_edge_r;
  logic [9:0]  w_clamp_l;
  logic [9:0]  w_clamp_r;

  // Widened operands, view cones and edge tests on the pre-update position.
  always_comb begin
    w_step     = (cam_step == 4'd0) ? 4'd1 : cam_step;
    w_x12      = {2'b00, r_camx};
    w_s12      = {2'b00, camS};
    w_st12     = {8'd0, w_step};
    w_p12      = {2'b00, playerX};
    w_lo_bound = (w_x12 >= VR12) ? (w_x12 - VR12) : 12'd0;
    w_sight_l  = player_valid && (w_p12 >= w_lo_bound) && (w_p12 <= w_x12);
    w_sight_r  = player_valid && (w_p12 >= w_x12) && (w_p12 <= (w_x12 + VR12));
    // x - camS - s <= MIN rearranged so nothing can go negative.
    w_edge_l   = (w_x12 <= (MIN12 + w_s12 + w_st12));
    w_edge_r   = ((w_x12 + w_s12 + w_st12) >= MAX12);
    w_clamp_l  = sat10(MIN12 + w_s12);
    w_clamp_r  = (w_s12 >= MAX12) ? 10'd0 : sat10(MAX12 - w_s12);
  end

  // Next-state and datapath decisions for one enabled frame tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_camx_nxt   = r_camx;
    w_cnt_nxt    = r_cnt;
    w_resume_nxt = r_resume_right;
    w_alert_nxt  = r_alert;
    case (r_state)
      ST_SWEEP_L: begin
        if (w_sight_l) begin
          w_state_nxt  = ST_ALERT;
          w_alert_nxt  = 1'b1;
          w_cnt_nxt    = ALERT_CNT;
          w_resume_nxt = 1'b0;
        end else if (w_edge_l) begin
          w_camx_nxt   = w_clamp_l;
          w_state_nxt  = ST_DWELL;
          w_resume_nxt = 1'b1;
          w_cnt_nxt    = DWELL_CNT;
        end else begin
          w_camx_nxt   = sat10(w_x12 - w_st12);
        end
      end
      ST_SWEEP_R: begin
        if (w_sight_r) begin
          w_state_nxt  = ST_ALERT;
          w_alert_nxt  = 1'b1;
          w_cnt_nxt    = ALERT_CNT;
          w_resume_nxt = 1'b1;
        end else if (w_edge_r) begin
          w_camx_nxt   = w_clamp_r;
          w_state_nxt  = ST_DWELL;
          w_resume_nxt = 1'b0;
          w_cnt_nxt    = DWELL_CNT;
        end else begin
          w_camx_nxt   = sat10(w_x12 + w_st12);
        end
      end
      ST_ALERT: begin
        if (w_sight_l || w_sight_r) begin
          w_cnt_nxt   = ALERT_CNT;
        end else if (r_cnt != 8'd0) begin
          w_cnt_nxt   = r_cnt - 8'd1;
        end else begin
          w_alert_nxt = 1'b0;
          w_state_nxt = r_resume_right ? ST_SWEEP_R : ST_SWEEP_L;
        end
      end
      ST_DWELL: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt   = r_cnt - 8'd1;
        end else begin
          w_state_nxt = r_resume_right ? ST_SWEEP_R : ST_SWEEP_L;
        end
      end
      default: begin
        w_state_nxt = ST_SWEEP_L;
      end
    endcase
  end

  // State and datapath registers advance only on enabled frame ticks.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state        <= ST_SWEEP_L;
      r_camx         <= START10;
      r_cnt          <= 8'd0;
      r_resume_right <= 1'b0;
      r_alert        <= 1'b0;
    end else if (frame_tick && enable) begin
      r_state        <= w_state_nxt;
      r_camx         <= w_camx_nxt;
      r_cnt          <= w_cnt_nxt;
      r_resume_right <= w_resume_nxt;
      r_alert        <= w_alert_nxt;
    end else begin
      r_state        <= r_state;
      r_camx         <= r_camx;
      r_cnt          <= r_cnt;
      r_resume_right <= r_resume_right;
      r_alert        <= r_alert;
    end
  end

  // Motion code follows the state, forced to stop while disabled.
  always_comb begin
    if (!enable) begin
      direction_cam = 2'b10;
    end else begin
      case (r_state)
        ST_SWEEP_L: direction_cam = 2'b00;
        ST_SWEEP_R: direction_cam = 2'b01;
        default:    direction_cam = 2'b10;
      endcase
    end
  end

  assign camX  = r_camx;
  assign alert = r_alert;

endmodule

// File: tb/tb_camera_patrol_ctrl.sv
// Directed plus randomized bench for camera_patrol_ctrl against a
// frame-level behavioural model of the patrol rules.
module tb_camera_patrol_ctrl;

  localparam int MINX  = 10;
  localparam int MAXX  = 639;
  localparam int START = 40;
  localparam int DWELL = 3;
  localparam int ALRT  = 5;
  localparam int VR    = 80;

  localparam int PAUSE_NONE  = 0;
  localparam int PAUSE_DWELL = 1;
  localparam int PAUSE_ALERT = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic       enable;
  logic [3:0] cam_step;
  logic [9:0] camS;
  logic [9:0] playerX;
  logic       player_valid;
  logic [9:0] camX;
  logic [1:0] direction_cam;
  logic       alert;

  int vectors    = 0;
  int miscompares = 0;

  // model: position, heading, pause kind and stationary frames remaining
  int m_x;
  bit m_right;
  int m_pause;
  int m_rem;
  bit m_resume_right;
  bit m_alert;

  camera_patrol_ctrl #(
    .CAM_X_MIN(MINX), .CAM_X_MAX(MAXX), .CAM_X_START(START),
    .DWELL_FRAMES(DWELL), .ALERT_FRAMES(ALRT), .VIEW_RANGE(VR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable),
    .cam_step(cam_step), .camS(camS), .playerX(playerX),
    .player_valid(player_valid), .camX(camX),
    .direction_cam(direction_cam), .alert(alert)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_x = START; m_right = 1'b0; m_pause = PAUSE_NONE;
    m_rem = 0; m_resume_right = 1'b0; m_alert = 1'b0;
  endtask

  task automatic model_tick();
    int s, lo, p, cs;
    bit in_l, in_r, seen;
    if (!enable) return;
    s  = (cam_step == 4'd0) ? 1 : int'(cam_step);
    p  = int'(playerX);
    cs = int'(camS);
    lo = (m_x - VR < 0) ? 0 : m_x - VR;
    in_l = player_valid && p >= lo && p <= m_x;
    in_r = player_valid && p >= m_x && p <= m_x + VR;
    if (m_pause == PAUSE_DWELL) begin
      m_rem--;
      if (m_rem == 0) begin
        m_pause = PAUSE_NONE;
        m_right = m_resume_right;
      end
    end else if (m_pause == PAUSE_ALERT) begin
      if (in_l || in_r) begin
        m_rem = ALRT;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_pause = PAUSE_NONE;
          m_alert = 1'b0;
          m_right = m_resume_right;
        end
      end
    end else begin
      seen = m_right ? in_r : in_l;
      if (seen) begin
        m_pause = PAUSE_ALERT; m_alert = 1'b1; m_rem = ALRT;
        m_resume_right = m_right;
      end else if (!m_right) begin
        if (m_x - cs - s <= MINX) begin
          m_x = (MINX + cs > 1023) ? 1023 : MINX + cs;
          m_pause = PAUSE_DWELL; m_rem = DWELL; m_resume_right = 1'b1;
        end else begin
          m_x = m_x - s;
        end
      end else begin
        if (m_x + cs + s >= MAXX) begin
          m_x = (MAXX - cs < 0) ? 0 : MAXX - cs;
          m_pause = PAUSE_DWELL; m_rem = DWELL; m_resume_right = 1'b0;
        end else begin
          m_x = m_x + s;
        end
      end
    end
  endtask

  task automatic check_val(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_all();
    int exp_dir;
    exp_dir = (!enable || m_pause != PAUSE_NONE) ? 2 : (m_right ? 1 : 0);
    check_val("camX", int'(camX), m_x);
    check_val("direction_cam", int'(direction_cam), exp_dir);
    check_val("alert", int'(alert), int'(m_alert));
  endtask

  task automatic tick();
    @(negedge Clk);
    frame_tick = 1'b1;
    model_tick();
    @(negedge Clk);
    frame_tick = 1'b0;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle();
    @(negedge Clk);
    check_all();
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; enable = 1'b1; cam_step = 4'd2;
    camS = 10'd5; playerX = 10'd0; player_valid = 1'b0;
    model_reset();
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;
    check_all();
    check_val("reset_camX", int'(camX), START);

    // reset and left sweep
    ticks(3);
    check_val("sweep_camX", int'(camX), 34);

    // left edge dwell and resume right
    ticks(10);
    check_val("dwell_entry_camX", int'(camX), 15);
    idle();
    ticks(3);
    tick();
    check_val("resume_right_camX", int'(camX), 17);

    // sighting in SWEEP_R, then expiry and resume
    cam_step = 4'd3;
    ticks(61);
    check_val("reach_200", int'(camX), 200);
    playerX = 10'd270; player_valid = 1'b1;
    tick();
    check_val("sight_alert", int'(alert), 1);
    player_valid = 1'b0; playerX = 10'd0;
    ticks(4);
    check_val("alert_held", int'(alert), 1);
    tick();
    check_val("alert_dropped", int'(alert), 0);
    tick();
    check_val("after_alert_camX", int'(camX), 203);

    // sighting beats the right edge
    cam_step = 4'd1;
    ticks(424);
    check_val("reach_627", int'(camX), 627);
    camS = 10'd10; cam_step = 4'd2; playerX = 10'd650; player_valid = 1'b1;
    tick();
    check_val("edge_vs_sight_camX", int'(camX), 627);
    player_valid = 1'b0;
    ticks(5);
    tick();
    check_val("right_clamp_camX", int'(camX), 629);
    ticks(3);

    // enable low, then cam_step zero
    enable = 1'b0;
    ticks(5);
    check_val("disabled_camX", int'(camX), 629);
    enable = 1'b1; cam_step = 4'd0;
    ticks(3);
    check_val("step0_camX", int'(camX), 626);

    // async reset mid-ALERT
    playerX = 10'd600; player_valid = 1'b1;
    tick();
    check_val("pre_reset_alert", int'(alert), 1);
    #1 Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 Reset = 1'b0;
    player_valid = 1'b0;

    // randomized frames, including idle cycles and parameter changes
    cam_step = 4'd2; camS = 10'd5;
    for (int n = 0; n < 600; n++) begin
      int px;
      enable       = ($urandom_range(0, 7) != 0);
      cam_step     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) camS = 10'($urandom_range(0, 40));
      player_valid = ($urandom_range(0, 3) == 0);
      px = m_x + int'($urandom_range(0, 220)) - 110;
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      playerX = 10'(px);
      if ($urandom_range(0, 3) == 0) idle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
